// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : op and FSM-state encodings shared by the MULT/DIV sequencer
// Rev 1.0
// ============================================================================
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// muldiv_step : one combinational Booth (MULT) or restoring (DIV) iteration
// Rev 1.0
// ============================================================================
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_op,
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_low,
  input  logic             i_qm1,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_low,
  output logic             o_qm1
);

  logic [WIDTH:0] w_mcand_sx;
  logic [WIDTH:0] w_booth_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_trial;

  always_comb begin
    w_mcand_sx  = {i_operand[WIDTH-1], i_operand};
    w_booth_sum = i_acc;
    w_rem_sh    = {i_acc[WIDTH-1:0], i_low[WIDTH-1]};
    w_trial     = w_rem_sh - {1'b0, i_operand};
    o_acc       = i_acc;
    o_low       = i_low;
    o_qm1       = 1'b0;

    if (i_op == OP_MULT) begin
      // acc carries one guard bit so subtracting the most negative multiplicand cannot overflow
      case ({i_low[0], i_qm1})
        2'b01:   w_booth_sum = i_acc + w_mcand_sx;
        2'b10:   w_booth_sum = i_acc - w_mcand_sx;
        default: w_booth_sum = i_acc;
      endcase
      o_acc = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
      o_low = {w_booth_sum[0], i_low[WIDTH-1:1]};
      o_qm1 = i_low[0];
    end else if (!w_trial[WIDTH]) begin
      o_acc = w_trial;
      o_low = {i_low[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = w_rem_sh;
      o_low = {i_low[WIDTH-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : iterative signed MULT/DIV with HI/LO and mthi/mtlo paths
// Optional: MULDIV_DIV0_EXC_EN short-circuits DIV by zero and raises div0.
// Rev 1.0
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     w_step_acc;
  logic [WIDTH-1:0]   w_step_low;
  logic               w_step_qm1;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_abs_a = a[WIDTH-1] ? -a : a;
  assign w_abs_b = b[WIDTH-1] ? -b : b;
  assign w_quot  = (sign_a_q ^ sign_b_q) ? -low_q : low_q;
  assign w_rem   = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_op      (op_q),
    .i_acc     (acc_q),
    .i_low     (low_q),
    .i_qm1     (qm1_q),
    .i_operand (opnd_q),
    .o_acc     (w_step_acc),
    .o_low     (w_step_low),
    .o_qm1     (w_step_qm1)
  );

`ifdef MULDIV_DIV0_EXC_EN
  logic div0_q, div0_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    bzero_d  = bzero_q;
    acc_d    = acc_q;
    low_d    = low_q;
    qm1_d    = qm1_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULDIV_DIV0_EXC_EN
    div0_d   = div0_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          op_d     = op;
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
          bzero_d  = (b == '0);
          acc_d    = '0;
          qm1_d    = 1'b0;
          if (op == OP_MULT) begin
            low_d  = b;
            opnd_d = a;
          end else begin
            low_d  = w_abs_a;
            opnd_d = w_abs_b;
          end
`ifdef MULDIV_DIV0_EXC_EN
          div0_d = 1'b0;
          if (op == OP_DIV && b == '0) begin
            state_d = S_DONE;
            div0_d  = 1'b1;
          end
`endif
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        acc_d = w_step_acc;
        low_d = w_step_low;
        qm1_d = w_step_qm1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (op_q == OP_MULT) begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = low_q;
        end else begin
          hi_d = w_rem;
          // a zero divisor leaves an all-ones quotient regardless of operand signs
          lo_d = bzero_q ? {WIDTH{1'b1}} : w_quot;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!start) begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      bzero_q  <= 1'b0;
      acc_q    <= '0;
      low_q    <= '0;
      qm1_q    <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      bzero_q  <= bzero_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      qm1_q    <= qm1_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

`ifdef MULDIV_DIV0_EXC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div0_q <= 1'b0;
    else       div0_q <= div0_d;
  end
  assign div0 = div0_q && (state_q == S_DONE);
`else
  assign div0 = 1'b0;
`endif

  assign busy = (state_q == S_CALC) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : scoreboard bench for the iterative MULT/DIV sequencer
// Rev 1.0
// ============================================================================
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           lat;
    logic         busy1;
  } exp_t;

  exp_t         sb_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  function automatic exp_t predict(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] cur_hi, input logic [W-1:0] cur_lo);
    exp_t   e;
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.div0  = 1'b0;
    e.lat   = W + 2;
    e.busy1 = 1'b1;
    e.hi    = cur_hi;
    e.lo    = cur_lo;
    if (!o) begin
      p = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
`ifdef MULDIV_DIV0_EXC_EN
      e.div0  = 1'b1;
      e.lat   = 1;
      e.busy1 = 1'b0;
`else
      e.hi = x;
      e.lo = '1;
`endif
    end else begin
      q = sx / sy;
      r = sx % sy;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int restart_cyc, input int hiwe_cyc, input bit start_in_done);
    exp_t e;
    int   cyc;
    bit   seen;
    e = predict(o, x, y, model_hi, model_lo);
    sb_q.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    checks++;
    if (busy !== e.busy1) begin
      errors++;
      $display("FAIL %s busy_c1: got %b want %b", name, busy, e.busy1);
    end
    seen = 0;
    while (!seen && cyc < 80) begin
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
        if (cyc == restart_cyc) begin
          start = 1'b1; op = ~o; a = 32'h0000_1234; b = 32'h0000_0003;
        end
        if (cyc == hiwe_cyc) begin
          hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        end
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    hi_we = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: got no done after %0d cycles want done", name, cyc);
    end else begin
      checks += 4;
      if (cyc !== e.lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
      end
      if (hi !== e.hi) begin
        errors++;
        $display("FAIL %s hi: got %h want %h", name, hi, e.hi);
      end
      if (lo !== e.lo) begin
        errors++;
        $display("FAIL %s lo: got %h want %h", name, lo, e.lo);
      end
      if (div0 !== e.div0) begin
        errors++;
        $display("FAIL %s div0: got %b want %b", name, div0, e.div0);
      end
    end
    if (start_in_done) begin
      start = 1'b1; op = 1'b0; a = 32'h0000_0009; b = 32'h0000_0009;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s start_in_done: got busy=%b done=%b want 0 0", name, busy, done);
      end
    end else begin
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick();
    tick();
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    if (div0 !== 1'b0) begin errors++; $display("FAIL reset div0: got %b want 0", div0); end
    if (hi !== '0) begin errors++; $display("FAIL reset hi: got %h want 0", hi); end
    if (lo !== '0) begin errors++; $display("FAIL reset lo: got %h want 0", lo); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mthi_mtlo();
    hi_we = 1'b1; wdata = 32'hA5A5_0001;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A_0002;
    tick();
    lo_we = 1'b0;
    model_hi = 32'hA5A5_0001;
    model_lo = 32'h5A5A_0002;
    checks += 2;
    if (hi !== model_hi) begin errors++; $display("FAIL mthi: got %h want %h", hi, model_hi); end
    if (lo !== model_lo) begin errors++; $display("FAIL mtlo: got %h want %h", lo, model_lo); end
  endtask

  task automatic test_mult();
    run_op("mult_7_m3",    1'b0, 32'd7,         32'hFFFF_FFFD, 0, 0, 0);
    run_op("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
    run_op("mult_mixed",   1'b0, 32'h1234_5678, 32'hFEDC_BA98, 0, 0, 0);
    run_op("mult_max_min", 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0);
    run_op("mult_rand",    1'b0, $urandom,      $urandom,      0, 0, 0);
  endtask

  task automatic test_div();
    run_op("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         0, 0, 0);
    run_op("div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("div_100_m7",  1'b1, 32'd100,       32'hFFFF_FFF9, 0, 0, 0);
    run_op("div_min_3",   1'b1, 32'h8000_0000, 32'd3,         0, 0, 0);
    run_op("div_3_10",    1'b1, 32'd3,         32'd10,        0, 0, 0);
  endtask

  task automatic test_div0();
    run_op("div_5_0", 1'b1, 32'd5, 32'd0, 0, 0, 0);
  endtask

  task automatic test_ignore();
    run_op("ignore_start_hiwe", 1'b0, 32'd7, 32'hFFFF_FFFD, 10, 12, 0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    int done_cnt;
    op = 1'b0; a = 32'h1111_1111; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      tick();
      cyc++;
    end
    reset = 1'b1;
    tick();
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rstmid done: got %b want 0", done); end
    if (hi !== '0) begin errors++; $display("FAIL rstmid hi: got %h want 0", hi); end
    if (lo !== '0) begin errors++; $display("FAIL rstmid lo: got %h want 0", lo); end
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL rstmid stray_done: got %0d pulses want 0", done_cnt);
    end
    run_op("mult_after_reset", 1'b0, 32'h1111_1111, 32'd3, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first",  1'b1, 32'd1000,      32'hFFFF_FFFD, 0, 0, 1);
    run_op("b2b_second", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op("b2b_third",  1'b1, 32'hFFFF_FF00, 32'hFFFF_FFF0, 0, 0, 0);
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div0();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
